fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Parametrised successor to the separate PC, nPC and Sumador4 blocks. It holds the SPARC-style PC/nPC pair, advances it by a configurable instruction step, and accepts redirects from decode: taken branches, `call` and `jmpl`. It implements delayed-branch semantics with the annul bit and drives the squash signal that selects the NOP path of the control-signal mux. It sits between instruction memory (`PC_Out`) and the IF/ID pipeline register.

## Interface
Parameters:
- `ADDR_W`, 32, PC/nPC width in bits.
- `RESET_PC`, 0, PC value after reset; nPC resets to `RESET_PC + STEP`.
- `STEP`, 4, byte increment per fetched instruction.

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge.
- `R`  in  1  reset, asynchronous and active-high.
- `LE`  in  1  load enable; 0 holds all state (stall).
- `redir_valid`  in  1  decode presents a control-transfer instruction this cycle.
- `redir_kind`  in  2  00 = conditional branch, 01 = branch-always, 10 = call, 11 = jmpl.
- `br_taken`  in  1  condition result; only meaningful for kind 00.
- `br_annul`  in  1  instruction bit 29 (`a`).
- `redir_target`  in  `ADDR_W`  target address; already computed by decode.
- `PC_Out`  out  `ADDR_W`  current fetch address.
- `nPC_Out`  out  `ADDR_W`  next PC.
- `fetch_valid`  out  1  PC_Out is a real fetch; 0 during the first cycle after reset.
- `squash`  out  1  the instruction now in ID is annulled; drives mux `S`.

## Operation
- Control-transfer take rule:
  - kinds 01, 10, 11: always taken;
  - kind 00: taken = `br_taken`.
- Annul rule. A delay slot is annulled when `br_annul` = 1 and either:
  - kind 00 is not taken; or
  - kind 01 is taken.
  - Kinds 10 and 11 never annul.
- Update at each edge with `LE` = 1:
  - taken redirect: `PC <= redir_target`, `nPC <= redir_target + STEP`;
  - otherwise: `PC <= nPC`, `nPC <= nPC + STEP`.
- The delay slot is always fetched. It is the instruction at the old PC and enters IF/ID at the same edge.
- Address arithmetic is modulo 2^`ADDR_W`. Wrap from the top address to 0 is silent.
- State machine:
  - `BOOT`: entered on reset. `fetch_valid` = 0. Moves to `RUN` on the first edge with `LE` = 1.
  - `RUN`: normal sequencing. A redirect that requires an annul moves to `SLOT_ANNUL`; otherwise stays in `RUN`.
  - `SLOT_ANNUL`: `squash` = 1 for exactly one ID cycle. Any `redir_valid` in this state is ignored, because it comes from the annulled slot. Returns to `RUN` on the next `LE` edge.
- Stall: `LE` = 0 freezes PC, nPC and the FSM state; a `squash` already asserted stays asserted. A redirect presented while `LE` = 0 is ignored; decode holds it and re-presents it.
- `R` asserted mid-operation: immediate asynchronous return to `BOOT`. Any pending annul is lost.

## Timing
- Reset values:
  - `PC_Out` = `RESET_PC`;
  - `nPC_Out` = `RESET_PC + STEP`;
  - `fetch_valid` = 0;
  - `squash` = 0;
  - state = `BOOT`.
- Redirect latency: 1 edge. The target appears on `PC_Out` in the cycle after `redir_valid`.
- `squash` is registered. It is high during the cycle the delay slot occupies ID, which is the cycle after the redirect.
- All outputs come from registers; there is no combinational path from inputs to outputs.

## Configuration
- `FETCH_ANNUL_EN` defined: annul rule and `SLOT_ANNUL` state as above.
- `FETCH_ANNUL_EN` undefined:
  - `br_annul` is ignored;
  - `squash` is tied to 0;
  - the FSM has only `BOOT` and `RUN`;
  - delay slots always execute.

## Structure
- Shared package holds:
  - the `redir_kind` encodings (`RK_BCOND`, `RK_BA`, `RK_CALL`, `RK_JMPL`);
  - the FSM state encoding;
  - the default `STEP` constant.
- One sub-module, `pc_reg`: an `ADDR_W`-wide register with async reset to a parameter value and load enable. It is instantiated twice, once for PC and once for nPC.
- Take/annul decode and the FSM live in the top module.

## Test plan
- Reset, then free-run with `LE` = 1 → `PC_Out` sequence 0, 4, 8, 12; `fetch_valid` = 0 only in the first cycle.
- Kind 00, taken, `a` = 0, target 0x40, presented at PC = 8 → `PC_Out` = 0x40, `nPC_Out` = 0x44 the next cycle; `squash` stays 0.
- Kind 00, not taken, `a` = 1 → sequential PC continues; `squash` = 1 for exactly one cycle. A `redir_valid` presented during that cycle is ignored.
- Kind 01, `a` = 1, target 0x80 → PC = 0x80 and `squash` = 1. Without `FETCH_ANNUL_EN`, `squash` stays 0.
- `LE` = 0 for 3 cycles while a redirect is presented, then `LE` = 1 → PC frozen during the stall; the redirect takes effect only at the first enabled edge.
- `R` pulsed during `SLOT_ANNUL` and with PC = 0xFFFFFFFC → immediate `PC_Out` = 0, `squash` = 0. Separately, sequential run from 0xFFFFFFFC → wraps to 0x00000000.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared encodings for the fetch PC unit: redirect kinds, FSM states, default step.
// FETCH_ANNUL_EN adds the SLOT_ANNUL state used for annulled delay slots.
package fetch_pc_unit_pkg;

    localparam int unsigned DEFAULT_STEP = 4;

    typedef enum logic [1:0] {
        RK_BCOND = 2'b00,
        RK_BA    = 2'b01,
        RK_CALL  = 2'b10,
        RK_JMPL  = 2'b11
    } redir_kind_e;

`ifdef FETCH_ANNUL_EN
    typedef enum logic [1:0] {
        ST_BOOT       = 2'b00,
        ST_RUN        = 2'b01,
        ST_SLOT_ANNUL = 2'b10
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01
    } fetch_state_e;
`endif

endpackage

// File: rtl/fetch_pc_unit_pc_reg.sv
// Address register with asynchronous reset to a parameter value and load enable.
// Used for both PC and nPC.
module pc_reg #(
    parameter int unsigned           W       = 32,
    parameter logic [W-1:0]          RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         le,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (le) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// SPARC-style PC/nPC sequencer with delayed branches and optional slot annul.
// Define FETCH_ANNUL_EN to enable the annul bit and the squash output.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       STEP     = DEFAULT_STEP
) (
    input  logic              Clk,
    input  logic              R,
    input  logic              LE,
    input  logic              redir_valid,
    input  logic [1:0]        redir_kind,
    input  logic              br_taken,
    input  logic              br_annul,
    input  logic [ADDR_W-1:0] redir_target,
    output logic [ADDR_W-1:0] PC_Out,
    output logic [ADDR_W-1:0] nPC_Out,
    output logic              fetch_valid,
    output logic              squash
);

    localparam logic [ADDR_W-1:0] STEP_V    = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] RESET_NPC = RESET_PC + STEP_V;

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    redir_kind_e       kind;
    logic              accept;
    logic              take;
    logic              annul;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] npc_d;

    assign kind = redir_kind_e'(redir_kind);

    // Only RUN trusts decode: BOOT has nothing in ID, SLOT_ANNUL holds a dead slot.
    assign accept = redir_valid && (state_q == ST_RUN);

    always_comb begin
        take = 1'b1;
        unique case (1'b1)
            (kind == RK_BCOND): take = br_taken;
            default:            take = 1'b1;
        endcase
    end

`ifdef FETCH_ANNUL_EN
    assign annul = br_annul
                && (((kind == RK_BCOND) && !br_taken)
                 || (kind == RK_BA));
`else
    logic annul_unused;
    assign annul_unused = br_annul;
    assign annul        = 1'b0;
`endif

    assign pc_d  = (accept && take) ? redir_target : nPC_Out;
    assign npc_d = pc_d + STEP_V;

    pc_reg #(
        .W       (ADDR_W),
        .RST_VAL (RESET_PC)
    ) u_pc (
        .clk (Clk),
        .rst (R),
        .le  (LE),
        .d   (pc_d),
        .q   (PC_Out)
    );

    pc_reg #(
        .W       (ADDR_W),
        .RST_VAL (RESET_NPC)
    ) u_npc (
        .clk (Clk),
        .rst (R),
        .le  (LE),
        .d   (npc_d),
        .q   (nPC_Out)
    );

    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            state_q <= ST_BOOT;
        end else if (LE) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
`ifdef FETCH_ANNUL_EN
                if (accept && annul) begin
                    state_d = ST_SLOT_ANNUL;
                end
`else
                state_d = (accept && annul) ? ST_RUN : ST_RUN;
`endif
            end
`ifdef FETCH_ANNUL_EN
            ST_SLOT_ANNUL: state_d = ST_RUN;
`endif
            default: state_d = ST_BOOT;
        endcase
    end

    assign fetch_valid = (state_q != ST_BOOT);

`ifdef FETCH_ANNUL_EN
    assign squash = (state_q == ST_SLOT_ANNUL);
`else
    assign squash = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a reference model pushes expected outputs
// per driven cycle; each test task pops and compares after the clock edge.
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

`ifdef FETCH_ANNUL_EN
    localparam bit ANNUL_EN = 1'b1;
`else
    localparam bit ANNUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        fv;
        logic        sq;
    } out_t;

    typedef struct {
        bit          le;
        bit          rv;
        logic [1:0]  k;
        bit          t;
        bit          a;
        logic [31:0] tgt;
    } stim_t;

    logic        Clk = 1'b0;
    logic        R = 1'b1;
    logic        LE = 1'b0;
    logic        redir_valid = 1'b0;
    logic [1:0]  redir_kind = 2'b00;
    logic        br_taken = 1'b0;
    logic        br_annul = 1'b0;
    logic [31:0] redir_target = '0;
    logic [31:0] PC_Out;
    logic [31:0] nPC_Out;
    logic        fetch_valid;
    logic        squash;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic [31:0] m_npc;
    int          m_st;
    out_t        sb[$];

    fetch_pc_unit dut (
        .Clk          (Clk),
        .R            (R),
        .LE           (LE),
        .redir_valid  (redir_valid),
        .redir_kind   (redir_kind),
        .br_taken     (br_taken),
        .br_annul     (br_annul),
        .redir_target (redir_target),
        .PC_Out       (PC_Out),
        .nPC_Out      (nPC_Out),
        .fetch_valid  (fetch_valid),
        .squash       (squash)
    );

    always #5 Clk = ~Clk;

    function automatic out_t m_out();
        out_t o;
        o.pc  = m_pc;
        o.npc = m_npc;
        o.fv  = (m_st != 0);
        o.sq  = (m_st == 2);
        return o;
    endfunction

    function automatic out_t obs();
        out_t o;
        o.pc  = PC_Out;
        o.npc = nPC_Out;
        o.fv  = fetch_valid;
        o.sq  = squash;
        return o;
    endfunction

    task automatic model_reset();
        m_pc  = 32'h0;
        m_npc = 32'h4;
        m_st  = 0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        R = 1'b1;
        LE = 1'b0;
        redir_valid = 1'b0;
        #2;
        R = 1'b0;
        model_reset();
    endtask

    // Drive one cycle at the falling edge and push what the model expects after the next rising edge.
    task automatic drive(input stim_t s);
        bit acc;
        bit tk;
        bit an;
        @(negedge Clk);
        LE = s.le;
        redir_valid = s.rv;
        redir_kind = s.k;
        br_taken = s.t;
        br_annul = s.a;
        redir_target = s.tgt;
        if (s.le) begin
            acc = s.rv && (m_st == 1);
            tk = (s.k != 2'b00) || s.t;
            an = ANNUL_EN && s.a
              && (((s.k == 2'b00) && !s.t) || (s.k == 2'b01));
            if (m_st != 1) m_st = 1;
            else if (acc && an) m_st = 2;
            m_pc = (acc && tk) ? s.tgt : m_npc;
            m_npc = m_pc + 32'd4;
        end
        sb.push_back(m_out());
    endtask

    localparam stim_t IDLE = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0};

    task automatic test_reset();
        out_t e;
        @(negedge Clk);
        R = 1'b1;
        #1;
        model_reset();
        sb.push_back(m_out());
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", obs(), e);
        end
        #1;
        R = 1'b0;
    endtask

    task automatic test_seq();
        out_t e;
        logic [31:0] want;
        do_reset();
        checks++;
        if (PC_Out !== 32'h0 || fetch_valid !== 1'b0) begin
            failures++;
            $display("FAIL seq_first pc=%h fv=%b exp pc=0 fv=0", PC_Out, fetch_valid);
        end
        for (int i = 1; i <= 3; i++) begin
            drive(IDLE);
            @(posedge Clk);
            #1;
            e = sb.pop_front();
            want = 32'(i * 4);
            checks++;
            if (obs() !== e || PC_Out !== want || fetch_valid !== 1'b1) begin
                failures++;
                $display("FAIL seq[%0d] got=%h exp=%h", i, obs(), e);
            end
        end
    endtask

    task automatic test_branch_taken();
        out_t e;
        stim_t s[$];
        s = '{IDLE, IDLE,
              '{1'b1, 1'b1, RK_BCOND, 1'b1, 1'b0, 32'h40},
              IDLE};
        do_reset();
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge Clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL bcond_taken[%0d] got=%h exp=%h", i, obs(), e);
            end
            if (i == 2) begin
                checks++;
                if (PC_Out !== 32'h40 || nPC_Out !== 32'h44 || squash !== 1'b0) begin
                    failures++;
                    $display("FAIL bcond_target pc=%h npc=%h sq=%b exp 40 44 0",
                             PC_Out, nPC_Out, squash);
                end
            end
        end
    endtask

    task automatic test_annul_nt();
        out_t e;
        stim_t s[$];
        s = '{IDLE,
              '{1'b1, 1'b1, RK_BCOND, 1'b0, 1'b1, 32'h200},
              '{1'b0, 1'b0, RK_BCOND, 1'b0, 1'b0, 32'h0},
              '{1'b1, 1'b1, RK_BA, 1'b1, 1'b0, 32'h300},
              IDLE, IDLE};
        do_reset();
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge Clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL annul_nt[%0d] got=%h exp=%h", i, obs(), e);
            end
        end
    endtask

    task automatic test_ba_annul();
        out_t e;
        stim_t s[$];
        s = '{IDLE,
              '{1'b1, 1'b1, RK_BA, 1'b1, 1'b1, 32'h80},
              IDLE, IDLE};
        do_reset();
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge Clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL ba_annul[%0d] got=%h exp=%h", i, obs(), e);
            end
            if (i == 1) begin
                checks++;
                if (PC_Out !== 32'h80 || squash !== ANNUL_EN) begin
                    failures++;
                    $display("FAIL ba_target pc=%h sq=%b exp pc=80 sq=%b",
                             PC_Out, squash, ANNUL_EN);
                end
            end
        end
    endtask

    task automatic test_stall();
        out_t e;
        stim_t s[$];
        stim_t r;
        r = '{1'b0, 1'b1, RK_BA, 1'b1, 1'b0, 32'h100};
        s = '{IDLE, IDLE, r, r, r};
        r.le = 1'b1;
        s.push_back(r);
        s.push_back(IDLE);
        do_reset();
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge Clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL stall[%0d] got=%h exp=%h", i, obs(), e);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_t e;
        stim_t s[$];
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0)
                s = '{IDLE, '{1'b1, 1'b1, RK_BCOND, 1'b0, 1'b1, 32'h500}};
            else
                s = '{IDLE, '{1'b1, 1'b1, RK_CALL, 1'b1, 1'b0, 32'hFFFF_FFFC}};
            do_reset();
            foreach (s[i]) begin
                drive(s[i]);
                @(posedge Clk);
                #1;
                e = sb.pop_front();
                checks++;
                if (obs() !== e) begin
                    failures++;
                    $display("FAIL rmid%0d_pre[%0d] got=%h exp=%h", pass, i, obs(), e);
                end
            end
            #2;
            R = 1'b1;
            #1;
            model_reset();
            checks++;
            if (PC_Out !== 32'h0 || nPC_Out !== 32'h4 || squash !== 1'b0
                || fetch_valid !== 1'b0) begin
                failures++;
                $display("FAIL rmid%0d pc=%h npc=%h sq=%b fv=%b exp 0 4 0 0",
                         pass, PC_Out, nPC_Out, squash, fetch_valid);
            end
            #1;
            R = 1'b0;
        end
    endtask

    task automatic test_wrap();
        out_t e;
        stim_t s[$];
        s = '{IDLE,
              '{1'b1, 1'b1, RK_JMPL, 1'b0, 1'b1, 32'hFFFF_FFF8},
              IDLE, IDLE, IDLE};
        do_reset();
        foreach (s[i]) begin
            drive(s[i]);
            @(posedge Clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL wrap[%0d] got=%h exp=%h", i, obs(), e);
            end
            if (i == 3) begin
                checks++;
                if (PC_Out !== 32'h0 || nPC_Out !== 32'h4) begin
                    failures++;
                    $display("FAIL wrap_zero pc=%h npc=%h exp 0 4", PC_Out, nPC_Out);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        test_reset();
        test_seq();
        test_branch_taken();
        test_annul_nt();
        test_ba_annul();
        test_stall();
        test_reset_mid();
        test_wrap();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left size=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
